// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: one data-memory transaction at a time over a
// req/gnt/rvalid bus. Handles lane alignment, byte enables and load extension.
module load_store_unit (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   logic        err_q;
   logic [2:0]  funct3_q;
   logic [1:0]  offset_q;

   logic        misaligned;
   logic        illegal;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] shifted;
   logic [31:0] load_data;

   // Request decode on the incoming execute-stage values, registered at accept.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_next    = 4'b0001 << addr_i[1:0];
            wdata_next = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << {addr_i[1], 1'b0};
            wdata_next = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
      if (we_i)
         illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
      else
         illegal = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
   end

   // Load extraction: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted   = mem_rdata_i >> {offset_q, 3'b000};
      load_data = shifted;
      case (funct3_q[1:0])
         2'b00:   load_data = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

   // Control outputs decode straight from state, so reset drops them at once.
   assign ready_o   = (state == IDLE);
   assign mem_req_o = (state == REQ);
   assign done_o    = (state == DONE);
   assign err_o     = (state == DONE) && err_q;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         err_q       <= 1'b0;
         funct3_q    <= 3'b000;
         offset_q    <= 2'b00;
         rdata_o     <= 32'h0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'h0;
         mem_be_o    <= 4'h0;
         mem_wdata_o <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  funct3_q    <= funct3_i;
                  offset_q    <= addr_i[1:0];
                  mem_we_o    <= we_i;
                  mem_addr_o  <= {addr_i[31:2], 2'b00};
                  mem_be_o    <= be_next;
                  mem_wdata_o <= wdata_next;
                  err_q       <= misaligned || illegal;
                  state       <= (misaligned || illegal) ? DONE : REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i)
                  state <= mem_we_o ? DONE : WAIT;
            end
            WAIT: begin
               if (mem_rvalid_i) begin
                  rdata_o <= load_data;
                  state   <= DONE;
               end
            end
            DONE: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
